// File: rtl/mac_skew_feeder.sv
// Operand feeder for one edge of the MAC systolic array: accepts vector beats and
// presents them to the PE lanes with a diagonal skew, plus skewed accumulator clears.
module mac_skew_feeder #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_LANES  = 4,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            start_i,
   input  logic [CNT_WIDTH-1:0]            k_len_i,
   input  logic [NUM_LANES*DATA_WIDTH-1:0] in_data_i,
   input  logic                            in_valid_i,
   output logic                            in_ready_o,
   output logic [NUM_LANES*DATA_WIDTH-1:0] lane_data_o,
   output logic [NUM_LANES-1:0]            lane_valid_o,
   output logic [NUM_LANES-1:0]            lane_clr_o,
   output logic                            busy_o,
   output logic                            done_o
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FEED,
      ST_DRAIN
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_WIDTH-1:0] r_k_len;
   logic [CNT_WIDTH-1:0] r_beat_cnt;
   logic [CNT_WIDTH-1:0] r_drain_cnt;
   logic                 r_done;
   logic                 w_start_acc;
   logic                 w_accept;
   logic                 w_last_beat;
   logic                 w_drain_end;

   // NOTE: every signal gets a default before the case so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_start_acc = 1'b0;
      w_accept    = 1'b0;
      w_last_beat = 1'b0;
      w_drain_end = 1'b0;
      in_ready_o  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start_i && (k_len_i != '0)) begin
               w_start_acc = 1'b1;
               w_state_nxt = ST_FEED;
            end
         end
         ST_FEED: begin
            in_ready_o = 1'b1;
            w_accept   = in_valid_i;
            if (in_valid_i && ((r_beat_cnt + CNT_WIDTH'(1)) == r_k_len)) begin
               w_last_beat = 1'b1;
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // The counter reaches zero on this edge; lane N-1 has taken its last operand.
            if (r_drain_cnt == CNT_WIDTH'(1)) begin
               w_drain_end = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state is updated only with non-blocking assignments.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_k_len     <= '0;
         r_beat_cnt  <= '0;
         r_drain_cnt <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done <= w_drain_end;
         if (w_start_acc) begin
            r_k_len    <= k_len_i;
            r_beat_cnt <= '0;
         end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
         end
         if (w_last_beat) begin
            r_drain_cnt <= CNT_WIDTH'(NUM_LANES);
         end else if (r_state == ST_DRAIN) begin
            r_drain_cnt <= r_drain_cnt - CNT_WIDTH'(1);
         end
      end
   end

   assign busy_o = (r_state != ST_IDLE);
   assign done_o = r_done;

   // Lane k is a (k+1)-deep shift chain; stage 0 captures zero data on a bubble.
   for (genvar g_lane = 0; g_lane < NUM_LANES; g_lane++) begin : g_skew
      logic [DATA_WIDTH-1:0] r_data_sr [g_lane+1];
      logic [g_lane:0]       r_vld_sr;
      logic [g_lane:0]       r_clr_sr;

      // NOTE: the data chain is reset too, because lane outputs must read zero after reset.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            r_vld_sr <= '0;
            r_clr_sr <= '0;
            for (int s = 0; s <= g_lane; s++) begin
               r_data_sr[s] <= '0;
            end
         end else begin
            r_vld_sr[0]  <= w_accept;
            r_clr_sr[0]  <= w_start_acc;
            r_data_sr[0] <= w_accept ? in_data_i[g_lane*DATA_WIDTH +: DATA_WIDTH] : '0;
            for (int s = 1; s <= g_lane; s++) begin
               r_vld_sr[s]  <= r_vld_sr[s-1];
               r_clr_sr[s]  <= r_clr_sr[s-1];
               r_data_sr[s] <= r_data_sr[s-1];
            end
         end
      end

      assign lane_data_o[g_lane*DATA_WIDTH +: DATA_WIDTH] = r_data_sr[g_lane];
      assign lane_valid_o[g_lane]                         = r_vld_sr[g_lane];
      assign lane_clr_o[g_lane]                           = r_clr_sr[g_lane];
   end

endmodule

// File: tb/tb_mac_skew_feeder.sv
// Scoreboard bench for mac_skew_feeder: the driver predicts per-lane arrival edges from
// the skew rules and queues them; a negedge monitor pops and compares every cycle.
module tb_mac_skew_feeder;

   localparam int DW = 16;
   localparam int NL = 4;
   localparam int CW = 8;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             start_i;
   logic [CW-1:0]    k_len_i;
   logic [NL*DW-1:0] in_data_i;
   logic             in_valid_i;
   logic             in_ready_o;
   logic [NL*DW-1:0] lane_data_o;
   logic [NL-1:0]    lane_valid_o;
   logic [NL-1:0]    lane_clr_o;
   logic             busy_o;
   logic             done_o;

   mac_skew_feeder #(
      .DATA_WIDTH(DW),
      .NUM_LANES (NL),
      .CNT_WIDTH (CW)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .k_len_i     (k_len_i),
      .in_data_i   (in_data_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .lane_data_o (lane_data_o),
      .lane_valid_o(lane_valid_o),
      .lane_clr_o  (lane_clr_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int            due;
      logic [DW-1:0] data;
   } beat_t;

   beat_t lane_q [NL][$];
   int    clr_q  [NL][$];
   int    done_q [$];

   int edge_no   = 0;
   int checks    = 0;
   int errors    = 0;
   bit mon_en    = 1'b0;
   bit exp_busy  = 1'b0;
   bit exp_ready = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s edge=%0d actual=%0h expected=%0h", name, edge_no, act, exp);
      end
   endtask

   // Edge numbering: during the cycle after edge e, edge_no == e.
   task automatic tick();
      @(posedge clk_i);
      edge_no++;
      #1;
   endtask

   function automatic logic [NL*DW-1:0] rand_beat();
      logic [NL*DW-1:0] r;
      for (int k = 0; k < NL; k++) r[k*DW +: DW] = DW'($urandom);
      return r;
   endfunction

   task automatic flush();
      for (int k = 0; k < NL; k++) begin
         lane_q[k].delete();
         clr_q[k].delete();
      end
      done_q.delete();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_data"},  64'(lane_data_o),  64'(0));
      check({tag, "_valid"}, 64'(lane_valid_o), 64'(0));
      check({tag, "_clr"},   64'(lane_clr_o),   64'(0));
      check({tag, "_ready"}, 64'(in_ready_o),   64'(0));
      check({tag, "_busy"},  64'(busy_o),       64'(0));
      check({tag, "_done"},  64'(done_o),       64'(0));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         start_i    = 1'b0;
         in_valid_i = 1'($urandom_range(1));
         in_data_i  = rand_beat();
         tick();
      end
   endtask

   // Runs one tile starting in the current (IDLE) cycle; returns in the done_o cycle,
   // or right after a reset edge when abort_after beats have been accepted.
   task automatic run_tile(input int klen, input int bubble_pct, input int bubble_at,
                           input bit seq_data, input bit noise_start, input int abort_after);
      int               beats;
      int               stall;
      bit               v;
      logic [NL*DW-1:0] d;
      beat_t            b;
      beats = 0;
      stall = 0;
      start_i    = 1'b1;
      k_len_i    = CW'(klen);
      in_valid_i = 1'b0;
      tick();
      start_i = 1'b0;
      for (int k = 0; k < NL; k++) clr_q[k].push_back(edge_no + k);
      exp_busy  = 1'b1;
      exp_ready = 1'b1;
      while (beats < klen) begin
         v = (stall >= 3) || (int'($urandom_range(99)) >= bubble_pct);
         if (beats == bubble_at && stall == 0) v = 1'b0;
         d = rand_beat();
         if (seq_data) begin
            for (int k = 0; k < NL; k++) d[k*DW +: DW] = DW'(beats*NL + k + 1);
         end
         in_valid_i = v;
         in_data_i  = d;
         start_i    = noise_start && ($urandom_range(3) == 0);
         k_len_i    = CW'($urandom_range(1, 255));
         tick();
         if (v) begin
            for (int k = 0; k < NL; k++) begin
               b.due  = edge_no + k;
               b.data = d[k*DW +: DW];
               lane_q[k].push_back(b);
            end
            beats++;
            stall = 0;
         end else begin
            stall++;
         end
         if (abort_after != 0 && beats == abort_after && beats < klen) begin
            in_valid_i = 1'b0;
            start_i    = 1'b0;
            rst_i      = 1'b1;
            tick();
            flush();
            exp_busy  = 1'b0;
            exp_ready = 1'b0;
            check_all_zero("rst_mid");
            rst_i = 1'b0;
            return;
         end
      end
      exp_ready = 1'b0;
      done_q.push_back(edge_no + NL);
      for (int i = 0; i < NL; i++) begin
         in_valid_i = 1'($urandom_range(1));
         in_data_i  = rand_beat();
         start_i    = noise_start && ($urandom_range(1) == 0);
         k_len_i    = CW'($urandom_range(1, 255));
         tick();
      end
      start_i    = 1'b0;
      in_valid_i = 1'b0;
      exp_busy   = 1'b0;
   endtask

   always @(negedge clk_i) begin : monitor
      bit            ev;
      bit            ec;
      bit            ed;
      logic [DW-1:0] edata;
      beat_t         b;
      if (mon_en) begin
         check("busy",     64'(busy_o),     64'(exp_busy));
         check("in_ready", 64'(in_ready_o), 64'(exp_ready));
         for (int k = 0; k < NL; k++) begin
            ev    = 1'b0;
            edata = '0;
            if (lane_q[k].size() > 0) begin
               b = lane_q[k][0];
               if (b.due == edge_no) begin
                  ev    = 1'b1;
                  edata = b.data;
                  void'(lane_q[k].pop_front());
               end
            end
            check($sformatf("lane%0d_valid", k), 64'(lane_valid_o[k]), 64'(ev));
            check($sformatf("lane%0d_data", k), 64'(lane_data_o[k*DW +: DW]), 64'(edata));
            ec = 1'b0;
            if (clr_q[k].size() > 0 && clr_q[k][0] == edge_no) begin
               ec = 1'b1;
               void'(clr_q[k].pop_front());
            end
            check($sformatf("lane%0d_clr", k), 64'(lane_clr_o[k]), 64'(ec));
         end
         ed = 1'b0;
         if (done_q.size() > 0 && done_q[0] == edge_no) begin
            ed = 1'b1;
            void'(done_q.pop_front());
         end
         check("done", 64'(done_o), 64'(ed));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog edge=%0d", edge_no);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int klen;
      int ab;
      rst_i      = 1'b1;
      start_i    = 1'b0;
      k_len_i    = '0;
      in_valid_i = 1'b0;
      in_data_i  = '0;
      tick();
      tick();
      check_all_zero("rst_init");
      rst_i  = 1'b0;
      mon_en = 1'b1;
      idle(2);

      // Basic tile with lane k of beat b = 4b+k+1, then the same tile with one bubble.
      run_tile(3, 0, -1, 1'b1, 1'b0, 0);
      idle(2);
      run_tile(3, 0, 1, 1'b1, 1'b0, 0);
      idle(1);

      // Zero-length start is ignored, then starts pulsed during FEED/DRAIN are ignored.
      start_i = 1'b1;
      k_len_i = '0;
      tick();
      start_i = 1'b0;
      idle(2);
      run_tile(4, 20, -1, 1'b0, 1'b1, 0);
      idle(1);

      // Reset after 2 of 5 beats, then a fresh single-beat tile.
      run_tile(5, 0, -1, 1'b0, 1'b0, 2);
      run_tile(1, 0, -1, 1'b0, 1'b0, 0);
      idle(1);

      // Back-to-back: second start is driven in the done_o cycle.
      run_tile(3, 0, -1, 1'b1, 1'b0, 0);
      run_tile(2, 0, -1, 1'b0, 1'b0, 0);
      idle(2);

      // Longest tile the counter allows.
      run_tile(255, 10, -1, 1'b0, 1'b1, 0);
      idle(2);

      repeat (30) begin
         klen = int'($urandom_range(1, 12));
         ab   = (klen > 1 && $urandom_range(5) == 0) ? int'($urandom_range(1, klen - 1)) : 0;
         run_tile(klen, int'($urandom_range(0, 50)), -1, 1'b0, 1'($urandom_range(1)), ab);
         if ($urandom_range(1) == 1) idle(int'($urandom_range(1, 3)));
      end
      idle(NL + 2);

      for (int k = 0; k < NL; k++) begin
         check($sformatf("lane%0d_pending", k), 64'(lane_q[k].size()), 64'(0));
         check($sformatf("clr%0d_pending", k), 64'(clr_q[k].size()), 64'(0));
      end
      check("done_pending", 64'(done_q.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mac_skew_feeder.md
# mac_skew_feeder

Operand feeder for one edge of the MAC systolic array, directly upstream of a column or row of `mac_pe` elements. It accepts one vector beat of `NUM_LANES` operands per cycle through a valid/ready handshake and produces per-lane data and valid with a diagonal skew: lane k lags lane 0 by k cycles. It also issues skewed per-lane accumulator clear pulses at tile start, and signals completion once the last lane's final operand has been consumed.

## Interface
- `DATA_WIDTH`, default 16: operand width per lane.
- `NUM_LANES`, default 4: number of PE lanes driven (≥1).
- `CNT_WIDTH`, default 8: width of the tile-length counter.

- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  tile start request; sampled only in IDLE.
- `k_len_i`  in  CNT_WIDTH  beats in the tile; latched on accepted start.
- `in_data_i`  in  NUM_LANES*DATA_WIDTH  beat; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH].
- `in_valid_i`  in  1  beat valid.
- `in_ready_o`  out  1  beat accepted when `in_valid_i & in_ready_o`.
- `lane_data_o`  out  NUM_LANES*DATA_WIDTH  skewed operands to PEs (`a_i`/`b_i`).
- `lane_valid_o`  out  NUM_LANES  skewed valids to PEs.
- `lane_clr_o`  out  NUM_LANES  skewed accumulator clears to PEs (`acc_clr_i`).
- `busy_o`  out  1  state ≠ IDLE.
- `done_o`  out  1  one-cycle pulse; all lanes have received their last operand.

## Operation
- States: IDLE, FEED, DRAIN.
- IDLE: `in_ready_o`=0. `start_i`=1 with `k_len_i`≠0: latch `k_len_i`, clear beat counter, inject a clear token into the clr skew chain, and go to FEED. `start_i` with `k_len_i`=0 is ignored.
- FEED: `in_ready_o`=1. Each accepted beat increments the beat counter. When the accepted beat makes the count equal to the latched `k_len`, go to DRAIN and load the drain counter with `NUM_LANES`.
- DRAIN: `in_ready_o`=0. The drain counter decrements each cycle. At zero, go to IDLE and pulse `done_o`.
- `start_i` in FEED or DRAIN is ignored; it is not queued.
- Skew chain: lane k uses a k+1-stage register delay for data, valid and clr. Lane 0 has one register.
- Data in a slot with valid=0 is forced to 0. A bubble, i.e. no accept in FEED, inserts an invalid zero slot that propagates with the same skew.
- Clr and valid are separate chains. They never coincide on a lane, because the clear token precedes the first possible beat by one cycle.
- Counters are CNT_WIDTH bits. `k_len_i` max is 2^CNT_WIDTH−1. Counters never wrap within a tile.

## Timing
- Reset (synchronous, any state): on the first edge with `rst_i`=1, state becomes IDLE and all skew registers clear. After that edge, `lane_data_o`=0, `lane_valid_o`=0, `lane_clr_o`=0, `in_ready_o`=0, `busy_o`=0, `done_o`=0. In-flight beats are discarded.
- Start accepted at edge E0: `lane_clr_o[k]`=1 for exactly the cycle between edges E0+k and E0+k+1. The first beat can be accepted at edge E1.
- Beat accepted at edge T: `lane_valid_o[k]`=1 and `lane_data_o[k]` = that beat's lane-k element during the cycle from edge T+k to edge T+k+1.
- Last beat accepted at edge L: DRAIN lasts edges L+1..L+N, where N=NUM_LANES. `done_o`=1 during cycle L+N..L+N+1, state is IDLE, and `busy_o`=0.
- In the `done_o` cycle every downstream PE accumulator already holds its final sum.
- `start_i` asserted during the `done_o` cycle is accepted. Back-to-back tiles are therefore separated by no idle cycle beyond `done_o`.

## Test plan
All scenarios use NUM_LANES=4, DATA_WIDTH=16.
- **Reset:** assert `rst_i` mid-sim, then release → all outputs 0 one edge after assertion; `busy_o`=0.
- **Basic tile:** start with `k_len`=3 at E0; beats {1,2,3,4}, {5,6,7,8}, {9,10,11,12} accepted at E1–E3 → `lane_clr_o[2]` high during E2..E3; lane 2 shows 3, 7, 11 valid at E3, E4, E5; lane 3 last valid (12) at E6; `done_o` during E7..E8. Optionally, with 4 `mac_pe` driven with b=1, the accumulators read 15/18/21/24 at `done_o`.
- **Bubble:** same tile with `in_valid_i`=0 for one cycle after the first beat → each lane shows one zero, invalid slot between the first and second operands, skewed per lane; `done_o` one cycle later than in the basic tile.
- **Ignored start:** `start_i` with `k_len_i`=0 in IDLE → no state change, no clr. `start_i` pulsed during FEED and DRAIN → no effect; a single `done_o` for the tile.
- **Reset mid-FEED:** assert `rst_i` after 2 of 5 beats → all lane outputs 0 after the next edge, IDLE; a fresh start with `k_len`=1 then completes normally, with `done_o` 5 cycles after the accept.
- **Back-to-back:** assert `start_i` (`k_len`=2) in the `done_o` cycle → new clr on lane 0 in the next cycle; the second tile completes with correct skew and no lost or duplicated beats.
